// File: rtl/pmc_pkg.sv
// rtl/pmc_pkg.sv - shared constants and state encoding for the PMC transmit path
package pmc_pkg;

  localparam int PMC_COLUMNS = 32;
  localparam int PMC_WORD_W  = 16;
  localparam int PMC_DIV_W   = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_LOW   = 2'd1,
    TX_PULSE = 2'd2,
    TX_TAIL  = 2'd3
  } pmc_tx_state_t;

  localparam logic [1:0] ST_IDLE  = TX_IDLE;
  localparam logic [1:0] ST_LOW   = TX_LOW;
  localparam logic [1:0] ST_PULSE = TX_PULSE;
  localparam logic [1:0] ST_TAIL  = TX_TAIL;

endpackage

// File: rtl/pmc_transmitter_if.sv
// rtl/pmc_transmitter_if.sv - firmware request and matrix framing signals of the PMC transmitter
interface pmc_transmitter_if;
  import pmc_pkg::*;

  logic                                  start;
  logic [PMC_DIV_W-1:0]                  clk_div;
  logic [PMC_COLUMNS-1:0][PMC_WORD_W-1:0] wdata;
  logic                                  busy;
  logic                                  done;
  logic                                  sh;
  logic                                  pclk;
  logic [PMC_COLUMNS-1:0]                pm_data_din;

  modport master (
    output start, clk_div, wdata,
    input  busy, done, sh, pclk, pm_data_din
  );

  modport slave (
    input  start, clk_div, wdata,
    output busy, done, sh, pclk, pm_data_din
  );

endinterface

// File: rtl/pmc_strobe_gen.sv
// rtl/pmc_strobe_gen.sv - reloadable down-counter; expired_o is high once the count reaches zero
module pmc_strobe_gen #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  // Counting down from the loaded value means a full-scale divider never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/pmc_transmitter.sv
// rtl/pmc_transmitter.sv - serialises 32 column words MSB first with sh/pclk framing
module pmc_transmitter
  import pmc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  pmc_transmitter_if.slave bus
);

  localparam int COLUMNS = PMC_COLUMNS;
  localparam int WORD_W  = PMC_WORD_W;
  localparam int DIV_W   = PMC_DIV_W;
  localparam int BCW     = $clog2(WORD_W);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_W - 1);

  logic [1:0]                     state_q, state_d;
  logic [BCW-1:0]                 bit_cnt_q, bit_cnt_d, sel_d;
  logic [DIV_W-1:0]               div_q, div_d, cnt_val;
  logic [COLUMNS-1:0][WORD_W-1:0] shadow_q, shadow_d;
  logic [COLUMNS-1:0]             data_q, data_d;
  logic                           sh_q, pclk_q, busy_q, done_q;
  logic                           cnt_load, expired;

  // Reload while not in a timed phase; on the start cycle take clk_div directly.
  assign cnt_load = (state_q == ST_IDLE) || (state_q == ST_PULSE);
  assign cnt_val  = (state_q == ST_IDLE) ? bus.clk_div : div_q;

  pmc_strobe_gen #(.W(DIV_W)) u_strobe (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .expired_o (expired)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    shadow_d  = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          shadow_d  = bus.wdata;
          div_d     = bus.clk_div;
          bit_cnt_d = '0;
          state_d   = ST_LOW;
        end
      end
      ST_LOW: begin
        if (expired) state_d = ST_PULSE;
      end
      ST_PULSE: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d = ST_TAIL;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = ST_LOW;
        end
      end
      ST_TAIL: begin
        if (expired) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next state so they line up with the state register.
  always_comb begin
    sel_d  = LAST_BIT - bit_cnt_d;
    data_d = '0;
    for (int i = 0; i < COLUMNS; i++) begin
      data_d[i] = (state_d != ST_IDLE) & shadow_d[i][sel_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      div_q     <= '0;
      shadow_q  <= '0;
      data_q    <= '0;
      sh_q      <= 1'b0;
      pclk_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      data_q    <= data_d;
      sh_q      <= (state_d != ST_IDLE);
      pclk_q    <= (state_d == ST_PULSE);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_q != ST_IDLE) && (state_d == ST_IDLE);
    end
  end

  assign bus.sh          = sh_q;
  assign bus.pclk        = pclk_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pm_data_din = data_q;

endmodule

// File: tb/tb_pmc_transmitter.sv
// tb/tb_pmc_transmitter.sv - directed bench for pmc_transmitter framing and serial data
module tb_pmc_transmitter;
  import pmc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pmc_transmitter_if bus ();

  pmc_transmitter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int tick = 0;
  int t0 = 0;
  always @(posedge clk) tick <= tick + 1;

  int          pulses[$];
  logic [15:0] rx[PMC_COLUMNS];
  int          done_cyc, busy_cnt;
  logic        ones_ok, sh_at_done, first_sh, inj_pending;
  logic [PMC_COLUMNS-1:0] data_at_done;
  logic [PMC_COLUMNS-1:0][15:0] wa, wb, wc;

  function automatic int exp_pulse(input int k, input int d);
    return 1 + (k + 1) * (d + 1) + k;
  endfunction

  task automatic start_frame(input logic [7:0] div, input logic [PMC_COLUMNS-1:0][15:0] w);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.clk_div = div; bus.wdata = w; t0 = tick;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Receiver model: shifts each lane in on every pclk strobe; stops at done or pulse limit.
  task automatic capture_frame(input int budget, input int stop_pulses, input logic inject);
    pulses.delete();
    done_cyc = -1; busy_cnt = 0; ones_ok = 1'b1; first_sh = 1'b0;
    sh_at_done = 1'b1; data_at_done = '1; inj_pending = 1'b0;
    for (int i = 0; i < PMC_COLUMNS; i++) rx[i] = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (inj_pending) begin bus.start = 1'b0; inj_pending = 1'b0; end
      if (c == 0) first_sh = bus.sh;
      if (bus.busy) busy_cnt++;
      if (bus.sh && bus.pm_data_din !== '1) ones_ok = 1'b0;
      if (bus.pclk) begin
        pulses.push_back(tick - t0);
        for (int i = 0; i < PMC_COLUMNS; i++) rx[i] = {rx[i][14:0], bus.pm_data_din[i]};
        if (inject && pulses.size() == 5) begin
          bus.start = 1'b1; bus.wdata = wb; bus.clk_div = 8'd7; inj_pending = 1'b1;
        end
        if (stop_pulses != 0 && pulses.size() == stop_pulses) break;
      end
      if (bus.done) begin
        done_cyc = tick - t0; sh_at_done = bus.sh; data_at_done = bus.pm_data_din;
        break;
      end
    end
    if (inj_pending) bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic bad;
    rst_n = 1'b0; bus.start = 1'b0; bus.clk_div = '0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.sh, bus.pclk, bus.busy, bus.done, bus.pm_data_din} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0", {bus.sh, bus.pclk, bus.busy, bus.done, bus.pm_data_din});
    end
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bus.sh !== 1'b0 || bus.pclk !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL idle_quiet got activity required none"); end
  endtask

  task automatic test_basic();
    int got;
    for (int i = 0; i < PMC_COLUMNS; i++) wa[i] = 16'hA5A5 ^ 16'(i);
    start_frame(8'd0, wa);
    capture_frame(200, 0, 1'b0);
    checks++;
    if (first_sh !== 1'b1) begin errors++; $display("FAIL basic_sh_rise got %b required 1", first_sh); end
    checks++;
    if (pulses.size() != 16) begin errors++; $display("FAIL basic_pulse_count got %0d required 16", pulses.size()); end
    for (int k = 0; k < 16; k++) begin
      got = (k < pulses.size()) ? pulses[k] : -1;
      checks++;
      if (got != 2 * k + 2) begin errors++; $display("FAIL basic_pulse%0d got %0d required %0d", k, got, 2 * k + 2); end
    end
    for (int i = 0; i < PMC_COLUMNS; i++) begin
      checks++;
      if (rx[i] !== wa[i]) begin errors++; $display("FAIL basic_lane%0d got %h required %h", i, rx[i], wa[i]); end
    end
    checks++;
    if (done_cyc != 34) begin errors++; $display("FAIL basic_done_cycle got %0d required 34", done_cyc); end
    checks++;
    if (sh_at_done !== 1'b0 || data_at_done !== '0) begin
      errors++; $display("FAIL basic_done_idle got sh=%b data=%h required 0", sh_at_done, data_at_done);
    end
    checks++;
    if (busy_cnt != 33) begin errors++; $display("FAIL basic_busy_cycles got %0d required 33", busy_cnt); end
  endtask

  task automatic test_div3();
    int got;
    for (int i = 0; i < PMC_COLUMNS; i++) wc[i] = 16'hFFFF;
    start_frame(8'd3, wc);
    capture_frame(300, 0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      got = (k < pulses.size()) ? pulses[k] : -1;
      checks++;
      if (got != exp_pulse(k, 3)) begin errors++; $display("FAIL div3_pulse%0d got %0d required %0d", k, got, exp_pulse(k, 3)); end
    end
    checks++;
    if (!ones_ok) begin errors++; $display("FAIL div3_all_ones got a zero bit required all ones"); end
    checks++;
    if (busy_cnt != 84) begin errors++; $display("FAIL div3_busy_cycles got %0d required 84", busy_cnt); end
    checks++;
    if (done_cyc != 85) begin errors++; $display("FAIL div3_done_cycle got %0d required 85", done_cyc); end
  endtask

  task automatic test_max_div();
    for (int i = 0; i < PMC_COLUMNS; i++) wc[i] = 16'h8001;
    start_frame(8'd255, wc);
    capture_frame(5000, 0, 1'b0);
    checks++;
    if (pulses.size() != 16 || pulses[0] != 257 || pulses[15] != 4112) begin
      errors++;
      $display("FAIL maxdiv_pulses got n=%0d first=%0d required n=16 first=257 last=4112",
               pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
    end
    checks++;
    if (done_cyc != 4369) begin errors++; $display("FAIL maxdiv_done_cycle got %0d required 4369", done_cyc); end
    checks++;
    if (rx[0] !== 16'h8001) begin errors++; $display("FAIL maxdiv_lane0 got %h required 8001", rx[0]); end
  endtask

  task automatic test_start_while_busy();
    logic bad;
    for (int i = 0; i < PMC_COLUMNS; i++) wb[i] = 16'h0F0F + 16'(i * 3);
    start_frame(8'd0, wa);
    capture_frame(200, 0, 1'b1);
    bus.wdata = wa; bus.clk_div = 8'd0;
    checks++;
    if (pulses.size() != 16) begin errors++; $display("FAIL busy_start_pulse_count got %0d required 16", pulses.size()); end
    checks++;
    if (done_cyc != 34) begin errors++; $display("FAIL busy_start_done_cycle got %0d required 34", done_cyc); end
    bad = 1'b0;
    for (int i = 0; i < PMC_COLUMNS; i++) if (rx[i] !== wa[i]) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL busy_start_data got lane0=%h required %h", rx[0], wa[0]); end
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.pclk !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL busy_start_ignored got second frame required none"); end
  endtask

  task automatic test_back_to_back();
    logic bad;
    start_frame(8'd0, wa);
    capture_frame(200, 0, 1'b0);
    bus.start = 1'b1; bus.wdata = wb; t0 = tick;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (sh_at_done !== 1'b0) begin errors++; $display("FAIL b2b_sh_gap got %b required 0", sh_at_done); end
    capture_frame(200, 0, 1'b0);
    checks++;
    if (first_sh !== 1'b1) begin errors++; $display("FAIL b2b_sh_return got %b required 1", first_sh); end
    checks++;
    if (pulses.size() != 16 || done_cyc != 34) begin
      errors++; $display("FAIL b2b_second_frame got n=%0d done=%0d required 16 and 34", pulses.size(), done_cyc);
    end
    bad = 1'b0;
    for (int i = 0; i < PMC_COLUMNS; i++) if (rx[i] !== wb[i]) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL b2b_second_data got lane1=%h required %h", rx[1], wb[1]); end
  endtask

  task automatic test_reset_mid();
    logic bad;
    start_frame(8'd0, wa);
    capture_frame(100, 7, 1'b0);
    checks++;
    if (pulses.size() != 7) begin errors++; $display("FAIL rstmid_reach got %0d required 7", pulses.size()); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.sh, bus.pclk, bus.busy, bus.done, bus.pm_data_din} !== '0) begin
      errors++; $display("FAIL rstmid_outputs got %h required 0", {bus.sh, bus.pclk, bus.busy, bus.done, bus.pm_data_din});
    end
    bad = 1'b0;
    repeat (5) begin @(negedge clk); if (bus.done !== 1'b0) bad = 1'b1; end
    rst_n = 1'b1;
    repeat (5) begin @(negedge clk); if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1; end
    checks++;
    if (bad) begin errors++; $display("FAIL rstmid_no_done got done/busy required 0"); end
    start_frame(8'd0, wb);
    capture_frame(200, 0, 1'b0);
    checks++;
    if (pulses.size() != 16 || done_cyc != 34) begin
      errors++; $display("FAIL rstmid_clean_frame got n=%0d done=%0d required 16 and 34", pulses.size(), done_cyc);
    end
    bad = 1'b0;
    for (int i = 0; i < PMC_COLUMNS; i++) if (rx[i] !== wb[i]) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL rstmid_data got lane2=%h required %h", rx[2], wb[2]); end
  endtask

  task automatic test_loopback();
    for (int i = 0; i < PMC_COLUMNS; i++) wc[i] = 16'h1357 * 16'(i + 1);
    start_frame(8'd1, wc);
    capture_frame(200, 0, 1'b0);
    for (int i = 0; i < PMC_COLUMNS; i++) begin
      checks++;
      if (rx[i] !== wc[i]) begin errors++; $display("FAIL loop_lane%0d got %h required %h", i, rx[i], wc[i]); end
    end
    checks++;
    if (done_cyc != 51) begin errors++; $display("FAIL loop_done_cycle got %0d required 51", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div3();
    test_max_div();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
